// File: rtl/pmem_arbiter.sv
// pmem_arbiter: shares one 128-bit physical-memory port between the I-cache and D-cache miss controllers
module pmem_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int LINE_W      = 128,
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              icache_pmem_read,
    input  logic [ADDR_W-1:0] icache_pmem_address,
    output logic [LINE_W-1:0] icache_pmem_rdata,
    output logic              icache_pmem_resp,
    input  logic              dcache_pmem_read,
    input  logic              dcache_pmem_write,
    input  logic [ADDR_W-1:0] dcache_pmem_address,
    input  logic [LINE_W-1:0] dcache_pmem_wdata,
    output logic [LINE_W-1:0] dcache_pmem_rdata,
    output logic              dcache_pmem_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);
    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, RELEASE} state_t;

    state_t            state;
    logic              last_d;
    logic [ADDR_W-5:0] line_q;
    logic              i_req;
    logic              d_req;
    logic              grant_d;
    logic              grant_i;

    // D wins when I is absent, when round-robin is off, or when I held the port last
    always_comb begin
        i_req   = icache_pmem_read;
        d_req   = dcache_pmem_read | dcache_pmem_write;
        grant_d = d_req && (!i_req || !ROUND_ROBIN || !last_d);
        grant_i = i_req && !grant_d;
    end

    // Transaction FSM: latch the winner, hold the strobe until memory answers, then one dead cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_d     <= 1'b0;
            line_q     <= '0;
            pmem_wdata <= '0;
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state      <= SERVE_D;
                        last_d     <= 1'b1;
                        line_q     <= dcache_pmem_address[ADDR_W-1:4];
                        pmem_wdata <= dcache_pmem_wdata;
                        pmem_write <= dcache_pmem_write;
                        pmem_read  <= !dcache_pmem_write;
                    end else if (grant_i) begin
                        state     <= SERVE_I;
                        last_d    <= 1'b0;
                        line_q    <= icache_pmem_address[ADDR_W-1:4];
                        pmem_read <= 1'b1;
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (pmem_resp) begin
                        state      <= RELEASE;
                        pmem_read  <= 1'b0;
                        pmem_write <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Forward the memory answer only to the requester currently holding the port
    always_comb begin
        icache_pmem_resp  = (state == SERVE_I) && pmem_resp;
        dcache_pmem_resp  = (state == SERVE_D) && pmem_resp;
        icache_pmem_rdata = icache_pmem_resp ? pmem_rdata : '0;
        dcache_pmem_rdata = dcache_pmem_resp ? pmem_rdata : '0;
    end

    assign pmem_address = {line_q, 4'b0};

    // A simultaneous D-cache fill and write-back is a controller bug; the write is served
    illegal_rw: assert property (@(posedge clk) disable iff (reset) !(dcache_pmem_read && dcache_pmem_write));
endmodule
